// File: rtl/pulse_stretcher.sv
// ---------------------------------------------------------------------------
// pulse_stretcher
//
// Purpose:
//   Turns single-cycle event pulses into a level that is held for a
//   programmable number of clock cycles. After each stretched pulse the block
//   forces a low hold-off gap, and it marks the end of each pulse with a
//   one-cycle done strobe.
//
// Parameters:
//   WIDTH    bit width of the length input and the remaining down-counter
//   HOLDOFF  cycles the output stays low after a pulse before a new trigger
//            is accepted (0 is legal)
//
// Ports:
//   clock      system clock, all state changes on its rising edge
//   reset_n    asynchronous active-low reset
//   trigger    request to start a pulse, sampled on the rising clock edge
//   length     pulse duration in cycles, sampled only when a trigger is taken
//   level_out  stretched output level
//   busy       high while a pulse or its hold-off gap is in progress
//   done       one-cycle strobe that follows the last high cycle of a pulse
//   remaining  high cycles still to go including the current one, else 0
//
// Optional feature:
//   Define PULSE_STRETCHER_RETRIGGER_EN to let a trigger during an active
//   pulse reload the counter, which extends the pulse with no done strobe for
//   the truncated part. Without it, triggers during a pulse are ignored.
// ---------------------------------------------------------------------------
module pulse_stretcher #(
  parameter int WIDTH   = 24,
  parameter int HOLDOFF = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             trigger,
  input  logic [WIDTH-1:0] length,
  output logic             level_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  // The hold-off counter only needs to hold the value HOLDOFF; keep it at
  // least one bit wide so that HOLDOFF of 0 or 1 still elaborates.
  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HOLDOFF
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_count;
  logic              accept;

  // A trigger carrying a zero length is not a request for a pulse at all.
  assign accept = trigger && (length != '0);

  // Single state machine. Every output is a register, so nothing on the
  // input side reaches an output within the same cycle. done defaults low
  // each cycle so it can only ever be a one-cycle strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      level_out  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      remaining  <= '0;
      hold_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_ACTIVE;
            remaining <= length;
            level_out <= 1'b1;
            busy      <= 1'b1;
          end
        end

        ST_ACTIVE: begin
          // With retriggering enabled a fresh request outranks the end of
          // the pulse, even on the final high cycle.
`ifdef PULSE_STRETCHER_RETRIGGER_EN
          if (accept) begin
            remaining <= length;
          end else
`endif
          // The "<= 1" test also stops the counter at 0 so it never wraps.
          if (remaining <= WIDTH'(1)) begin
            level_out <= 1'b0;
            remaining <= '0;
            done      <= 1'b1;
            if (HOLDOFF > 0) begin
              state      <= ST_HOLDOFF;
              hold_count <= HOLD_W'(HOLDOFF);
              busy       <= 1'b1;
            end else begin
              // The trigger on this final edge is not taken; the earliest
              // restart is the next edge, leaving one low cycle with done.
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            remaining <= remaining - WIDTH'(1);
          end
        end

        ST_HOLDOFF: begin
          // Triggers are dropped here rather than queued.
          if (hold_count <= HOLD_W'(1)) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            hold_count <= '0;
          end else begin
            hold_count <= hold_count - HOLD_W'(1);
          end
        end

        default: begin
          state      <= ST_IDLE;
          level_out  <= 1'b0;
          busy       <= 1'b0;
          remaining  <= '0;
          hold_count <= '0;
        end
      endcase
    end
  end

endmodule
